// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver feeding io_ctl through a dout/d_rdy/rd handshake.
// Define UART_RX_PARITY_EN to insert an even-parity bit (8E1) with parity_err reporting.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       d_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_rx: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
            $error("uart_rx: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_sync;
    logic [DIV_W-1:0] r_div;
    logic [S_W-1:0]   r_s_ctr, w_s_ctr_nx;
    logic [2:0]       r_b_ctr, w_b_ctr_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic [7:0]       r_dout;
    logic             r_d_rdy, r_frame_err, r_overrun;
    logic             w_rx_s, w_tick, w_div_clr, w_deliver, w_ferr;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad, w_par_bad_nx, r_parity_err, w_perr;
`endif

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_s_ctr_nx = r_s_ctr;
        w_b_ctr_nx = r_b_ctr;
        w_shift_nx = r_shift;
        w_div_clr  = 1'b0;
        w_deliver  = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx = r_par_bad;
        w_perr       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nx = S_START;
                    w_s_ctr_nx = '0;
                    w_div_clr  = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_s_ctr == S_MID) begin
                        w_s_ctr_nx = '0;
                        w_b_ctr_nx = '0;
                        w_state_nx = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_s_ctr_nx = r_s_ctr + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_s_ctr == S_LAST) begin
                        w_s_ctr_nx = '0;
                        w_shift_nx = {w_rx_s, r_shift[7:1]};
                        if (r_b_ctr == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nx = S_PARITY;
`else
                            w_state_nx = S_STOP;
`endif
                        end else begin
                            w_b_ctr_nx = r_b_ctr + 3'd1;
                        end
                    end else begin
                        w_s_ctr_nx = r_s_ctr + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    if (r_s_ctr == S_LAST) begin
                        w_s_ctr_nx   = '0;
                        w_par_bad_nx = w_rx_s ^ (^r_shift);
                        w_state_nx   = S_STOP;
                    end else begin
                        w_s_ctr_nx = r_s_ctr + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                // Leaving at the stop mid-sample lets IDLE catch a back-to-back start edge.
                if (w_tick) begin
                    if (r_s_ctr == S_LAST) begin
                        if (w_rx_s) begin
                            w_state_nx = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            w_perr    = r_par_bad;
                            w_deliver = !r_par_bad;
`else
                            w_deliver = 1'b1;
`endif
                        end else begin
                            w_ferr     = 1'b1;
                            w_state_nx = S_WAIT;
                        end
                    end else begin
                        w_s_ctr_nx = r_s_ctr + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_rx_s) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_s_ctr     <= '0;
            r_b_ctr     <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_d_rdy     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx};
            r_state     <= w_state_nx;
            r_div       <= (w_div_clr || w_tick) ? '0 : r_div + 1'b1;
            r_s_ctr     <= w_s_ctr_nx;
            r_b_ctr     <= w_b_ctr_nx;
            r_shift     <= w_shift_nx;
            r_frame_err <= w_ferr;
            r_overrun   <= w_deliver && r_d_rdy && !rd;
            if (w_deliver) begin
                r_dout  <= r_shift;
                r_d_rdy <= 1'b1;
            end else if (rd) begin
                r_d_rdy <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nx;
            r_parity_err <= w_perr;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign dout      = r_dout;
    assign d_rdy     = r_d_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
